// File: rtl/led_snake_pkg.sv
// Shared definitions for the LED snake design: pulse generator FSM states and
// default burst parameters that must agree with the downstream pulse counter.
package led_snake_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pg_state_e;

   localparam int CNT_MAX_DEF  = 24;
   localparam int HIGH_CYC_DEF = 4;
   localparam int LOW_CYC_DEF  = 4;

endpackage

// File: rtl/pulse_gen_phase_timer.sv
// Loadable down-counter with a zero flag; times both the high and low phases
// of the pulse train.
module phase_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// Pulse-train transmitter: emits a clamped number of fixed-width pulses per
// start request. Define PULSE_GEN_ABORT_EN to add the abort_i input.
module pulse_gen
   import led_snake_pkg::*;
#(
   parameter int CNT_MAX  = CNT_MAX_DEF,
   parameter int CNT_W    = 5,
   parameter int HIGH_CYC = HIGH_CYC_DEF,
   parameter int LOW_CYC  = LOW_CYC_DEF,
   parameter int PH_W     = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] n_pulses_i,
   output logic             out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] sent_o
`ifdef PULSE_GEN_ABORT_EN
   ,
   input  logic             abort_i
`endif
);

   localparam logic [CNT_W-1:0] CntMax   = CNT_W'(CNT_MAX);
   localparam logic [PH_W-1:0]  HighLoad = PH_W'(HIGH_CYC - 1);
   localparam logic [PH_W-1:0]  LowLoad  = PH_W'(LOW_CYC - 1);

   pg_state_e        state_q, state_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] clamped;
   logic             tmr_load;
   logic [PH_W-1:0]  tmr_val;
   logic             tmr_zero;

   assign clamped = (n_pulses_i > CntMax) ? CntMax : n_pulses_i;

   phase_timer #(
      .W(PH_W)
   ) u_phase_timer (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load_i(tmr_load),
      .val_i (tmr_val),
      .zero_o(tmr_zero)
   );

   // An IDLE cycle with busy set is the tail of a zero-count burst.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sent_d   = sent_q;
      target_d = target_q;
      tmr_load = 1'b0;
      tmr_val  = HighLoad;
      case (state_q)
         IDLE: begin
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else if (start_i) begin
               target_d = clamped;
               sent_d   = '0;
               busy_d   = 1'b1;
               if (clamped != '0) begin
                  state_d  = HIGH;
                  out_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = HighLoad;
               end
            end
         end
         HIGH: begin
            if (tmr_zero) begin
               state_d  = LOW;
               out_d    = 1'b0;
               sent_d   = sent_q + CNT_W'(1);
               tmr_load = 1'b1;
               tmr_val  = LowLoad;
            end
         end
         LOW: begin
            if (tmr_zero) begin
               if (sent_q < target_q) begin
                  state_d  = HIGH;
                  out_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = HighLoad;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            out_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
`ifdef PULSE_GEN_ABORT_EN
      // Abort overrides any phase transition; a cut-short high phase is not counted.
      if (abort_i && busy_q && (state_q != IDLE)) begin
         state_d  = IDLE;
         out_d    = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b1;
         sent_d   = sent_q;
         tmr_load = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         out_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sent_q   <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sent_q   <= sent_d;
         target_q <= target_d;
      end
   end

   assign out_o  = out_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sent_o = sent_q;

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Pulse-train transmitter for the LED snake design. It drives the edge-counted input of the pulse counter. On a `start` request it emits a programmed number of clean, fixed-width high pulses separated by fixed low gaps, then reports completion. Pulse count is clamped to the counter's overflow limit so the downstream counter never sees more than `CNT_MAX` pulses.

## Interface
- `CNT_MAX`, 24: maximum pulses per burst; must match the receiving counter's limit.
- `CNT_W`, 5: width of count ports; must satisfy 2^CNT_W > CNT_MAX.
- `HIGH_CYC`, 4: clock cycles `out` stays high per pulse, ≥1.
- `LOW_CYC`, 4: clock cycles `out` stays low after each pulse, ≥1.
- `PH_W`, 8: width of the phase timer; must hold max(HIGH_CYC, LOW_CYC).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only while `busy`=0.
- `n_pulses`  in  CNT_W  requested pulse count; latched with accepted `start`.
- `out`  out  1  registered pulse-train output.
- `busy`  out  1  high from the cycle after acceptance until burst end.
- `done`  out  1  one-cycle completion strobe.
- `sent`  out  CNT_W  pulses completed in the current or last burst.
- `abort`  in  1  present only with `PULSE_GEN_ABORT_EN`.

## Operation
- States: IDLE, HIGH, LOW.
- IDLE:
  - On `start`=1, latch target = min(`n_pulses`, CNT_MAX), clear `sent` to 0 and set `busy`.
  - Target 0 → stay IDLE, assert `done` next cycle, `out` stays 0.
  - Target ≥1 → go to HIGH, `out`=1.
- HIGH: hold for HIGH_CYC cycles, then `out`=0, `sent`+1, and go to LOW.
- LOW: hold for LOW_CYC cycles.
  - If `sent` < target → go to HIGH.
  - Otherwise → go to IDLE, clear `busy`, pulse `done`.
- `start` while `busy`=1 is ignored. It is not queued, and `n_pulses` changes are ignored.
- `start` in the same cycle `done`=1 is accepted (`busy` is already 0).
- `sent` holds its final value in IDLE until the next accepted `start`. It never exceeds CNT_MAX, with no wrap.
- Phase timer counts down from HIGH_CYC-1 or LOW_CYC-1. All arithmetic is unsigned, with no overflow path.
- Reset values: `out`=0, `busy`=0, `done`=0, `sent`=0, state IDLE. Reset mid-burst clears everything immediately (asynchronous). The burst is lost and no `done` is issued.

## Timing
- `start` sampled at edge k → `out`=1 and `busy`=1 visible after edge k.
- Pulse i (1-based):
  - rises at k + (i-1)(HIGH_CYC+LOW_CYC);
  - falls HIGH_CYC cycles later, when `sent` becomes i.
- Burst of N pulses: `busy` high for exactly N·(HIGH_CYC+LOW_CYC) cycles.
  - `done` rises on the same edge `busy` falls, and lasts 1 cycle.
- Trailing LOW phase is always completed before `done`. Back-to-back bursts therefore keep the ≥LOW_CYC gap.
- Zero-count burst: `busy`=1 for 1 cycle, then `done`=1 for 1 cycle.
- `done` and `busy` are never both 1.

## Configuration
- `PULSE_GEN_ABORT_EN` defined: adds the `abort` input.
  - `abort`=1 while `busy` → next edge forces `out`=0, `busy`=0, `done`=1 for one cycle, state IDLE.
  - `sent` keeps pulses completed so far; a truncated high phase is not counted.
  - `abort` has priority over phase transitions. It is ignored in IDLE.
- Undefined: no `abort` port, and bursts always run to completion.

## Structure
- Shared package `led_snake_pkg`:
  - state enum (IDLE, HIGH, LOW);
  - default CNT_MAX=24, shared with the counter;
  - default HIGH_CYC and LOW_CYC constants.
- One natural sub-module: `phase_timer`, a loadable down-counter with a zero flag that times both phases.
- Everything else stays flat in `pulse_gen`.

## Test plan
- Reset, then `start` with `n_pulses`=3, HIGH_CYC=LOW_CYC=4.
  - Expect 3 pulses, each 4 cycles high and 4 low, `busy` for 24 cycles.
  - Expect `done` for 1 cycle and `sent`=3.
- `n_pulses`=0.
  - Expect `out` never high, `busy` for 1 cycle, then `done`.
- `n_pulses`=31 with CNT_MAX=24.
  - Expect exactly 24 pulses and `sent`=24; the pulse counter reports `ovf`=1.
- Re-pulse `start` mid-burst with `n_pulses`=7.
  - Expect it ignored and the original count completed.
  - Then `start` in the `done` cycle → new burst begins on the next edge.
- Drop `rst_n` during pulse 2 high phase.
  - Expect `out`, `busy` and `sent` at 0 immediately, with no `done` after release.
- With `PULSE_GEN_ABORT_EN`: `abort` in the 2nd cycle of pulse 3.
  - Expect `out`=0 next edge, `done` for 1 cycle, `sent`=2.
